// File: rtl/cmp_pkg.sv
// Shared definitions for the arbitrated magnitude-compare block:
// compare-function select codes and their type.
package cmp_pkg;

  typedef logic [2:0] cmp_sel_t;

  localparam cmp_sel_t SEL_ZERO = 3'b000;
  localparam cmp_sel_t SEL_ONE  = 3'b001;
  localparam cmp_sel_t SEL_EQ   = 3'b010;
  localparam cmp_sel_t SEL_NE   = 3'b011;
  localparam cmp_sel_t SEL_GE   = 3'b100;
  localparam cmp_sel_t SEL_LE   = 3'b101;
  localparam cmp_sel_t SEL_NAND = 3'b110;
  localparam cmp_sel_t SEL_GT   = 3'b111;

endpackage

// File: rtl/comparator_ds.sv
// Combinational unsigned magnitude comparator with a 3-bit function select,
// built from a single greater-than and a single equality term.
module comparator_ds
  import cmp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   sel_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         result_o
);

  logic gt;
  logic eq;

  assign gt = (a_i > b_i);
  assign eq = (a_i == b_i);

  always_comb begin
    result_o = 1'b0;
    case (cmp_sel_t'(sel_i))
      SEL_ZERO: result_o = 1'b0;
      SEL_ONE:  result_o = 1'b1;
      SEL_EQ:   result_o = eq;
      SEL_NE:   result_o = !eq;
      SEL_GE:   result_o = gt | eq;
      SEL_LE:   result_o = !gt;
      SEL_NAND: result_o = !(gt & eq);
      SEL_GT:   result_o = gt;
      default:  result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one compare unit between NREQ requesters, with a
// single registered, backpressured response slot tagged by requester index.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_sel,
  input  logic [N*NREQ-1:0] req_a,
  input  logic [N*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_out,
  output logic [15:0]       cmp_count
);

  logic [2:0]   sel_arr [NREQ];
  logic [N-1:0] a_arr   [NREQ];
  logic [N-1:0] b_arr   [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign sel_arr[gi] = req_sel[3*gi +: 3];
      assign a_arr[gi]   = req_a[N*gi +: N];
      assign b_arr[gi]   = req_b[N*gi +: N];
    end
  endgenerate

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_out_q, rsp_out_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]    cmp_count_q, cmp_count_d;

  logic [2*NREQ-1:0] valid_dbl;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic              slot_free;
  logic              gnt_en;
  logic              cmp_result;

  // Doubling the request vector turns the wrap-around search into a linear one.
  assign valid_dbl = {req_valid, req_valid};

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < 2*NREQ; k++) begin
      if (!gnt_found && (k >= int'(rr_ptr_q)) && valid_dbl[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = (k < NREQ) ? IDW'(k) : IDW'(k - NREQ);
      end
    end
  end

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign gnt_en    = gnt_found && slot_free && !rst;
  assign req_ready = gnt_en ? (NREQ'(1) << gnt_idx) : '0;

  comparator_ds #(.N(N)) u_cmp (
    .sel_i    (sel_arr[gnt_idx]),
    .a_i      (a_arr[gnt_idx]),
    .b_i      (b_arr[gnt_idx]),
    .result_o (cmp_result)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rr_ptr_d    = rr_ptr_q;
    cmp_count_d = cmp_count_q;
    if (rsp_valid_q && rsp_ready) begin
      cmp_count_d = cmp_count_q + 16'd1;
    end
    if (gnt_en) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_out_d   = cmp_result;
      // Explicit wrap keeps the pointer in range when NREQ is not a power of 2.
      rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= 1'b0;
      rr_ptr_q    <= '0;
      cmp_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rr_ptr_q    <= rr_ptr_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign cmp_count = cmp_count_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model; a second NREQ=3 instance covers pointer wrap.
module tb_cmp_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NREQ=4 instance
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_sel;
  logic [N*NREQ-1:0] req_a;
  logic [N*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_out;
  logic [15:0]       cmp_count;

  cmp_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .cmp_count (cmp_count)
  );

  // NREQ=3 instance
  logic          rst3;
  logic [2:0]    req_valid3;
  logic [2:0]    req_ready3;
  logic [8:0]    req_sel3;
  logic [23:0]   req_a3;
  logic [23:0]   req_b3;
  logic          rsp_valid3;
  logic          rsp_ready3;
  logic [1:0]    rsp_id3;
  logic          rsp_out3;
  logic [15:0]   cmp_count3;

  cmp_arbiter #(.N(N), .NREQ(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_sel   (req_sel3),
    .req_a     (req_a3),
    .req_b     (req_b3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_id    (rsp_id3),
    .rsp_out   (rsp_out3),
    .cmp_count (cmp_count3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit m_valid;
  int m_id;
  bit m_out;
  int m_count;
  int m_ptr;

  function automatic bit ref_cmp(input int sel, input int a, input int b);
    case (sel)
      0: return 1'b0;
      1: return 1'b1;
      2: return a == b;
      3: return a != b;
      4: return a >= b;
      5: return a <= b;
      6: return 1'b1;
      default: return a > b;
    endcase
  endfunction

  function automatic int pick_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int d = 0; d < NREQ; d++) begin
      if (req_valid[(m_ptr + d) % NREQ]) return (m_ptr + d) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: check against the model, then advance the model at the edge.
  task automatic step(output int g);
    #1;
    g = pick_grant();
    check_eq("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("rsp_id", 32'(rsp_id), m_id);
      check_eq("rsp_out", 32'(rsp_out), 32'(m_out));
    end
    check_eq("cmp_count", 32'(cmp_count), m_count & 32'hffff);
    if (g >= 0)
      $display("[TB] t=%0t grant req%0d sel=%0d a=0x%02h b=0x%02h", $time, g,
               req_sel[3*g +: 3], req_a[N*g +: N], req_b[N*g +: N]);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_out = 0; m_count = 0; m_ptr = 0;
    end else begin
      if (m_valid && rsp_ready) m_count++;
      if (g >= 0) begin
        m_out   = ref_cmp(int'(req_sel[3*g +: 3]), int'(req_a[N*g +: N]), int'(req_b[N*g +: N]));
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input int sel, input int a, input int b);
    req_valid[i]       = v;
    req_sel[3*i +: 3]  = 3'(sel);
    req_a[N*i +: N]    = 8'(a);
    req_b[N*i +: N]    = 8'(b);
  endtask

  task automatic new_data(input int i);
    req_sel[3*i +: 3] = 3'($urandom_range(0, 7));
    req_a[N*i +: N]   = 8'($urandom);
    req_b[N*i +: N]   = ($urandom_range(0, 3) == 0) ? req_a[N*i +: N] : 8'($urandom);
  endtask

  initial begin
    int g;
    int prev;
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_sel = '0; req_a = '0; req_b = '0;
    rst3 = 1'b1; rsp_ready3 = 1'b1; req_valid3 = '0; req_sel3 = '0; req_a3 = '0; req_b3 = '0;
    m_valid = 0; m_id = 0; m_out = 0; m_count = 0; m_ptr = 0;
    @(negedge clk);

    // Reset
    step(g); step(g);
    rst = 1'b0;
    #1;
    check_eq("reset_id", 32'(rsp_id), 0);
    check_eq("reset_out", 32'(rsp_out), 0);
    step(g);

    // Single request
    rsp_ready = 1'b1;
    set_req(2, 1, 7, 'h90, 'h10);
    #1 check_eq("single_ready", 32'(req_ready), 32'b0100);
    step(g);
    req_valid[2] = 1'b0;
    #1 check_eq("single_rsp", {29'd0, rsp_valid, rsp_id}, 32'b110);
    check_eq("single_out", 32'(rsp_out), 1);
    step(g);
    #1 check_eq("single_count", 32'(cmp_count), 1);
    step(g);

    // Function sweep
    for (int s = 0; s < 8; s++) begin
      set_req(s % NREQ, 1, s, 'h55, 'h55);
      step(g);
      set_req(s % NREQ, 1, s, 'h54, 'h55);
      step(g);
      req_valid = '0;
      step(g);
    end

    // Round-robin from a fresh pointer
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin req_valid[i] = 1'b1; new_data(i); end
    for (int k = 0; k < 8; k++) begin
      #1 check_eq("rr_order", 32'(req_ready), 1 << (k % NREQ));
      step(g);
      if (g >= 0) new_data(g);
    end
    req_valid = '0;
    step(g);
    #1 check_eq("rr_count", 32'(cmp_count), 8);

    // Backpressure
    set_req(0, 1, 1, 0, 0);
    step(g);
    req_valid[0] = 1'b0;
    set_req(1, 1, 7, 'h20, 'h10);
    set_req(3, 1, 0, 'h20, 'h10);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("bp_ready", 32'(req_ready), 0);
      check_eq("bp_hold", {30'd0, rsp_valid, rsp_out}, 32'b11);
      check_eq("bp_id", 32'(rsp_id), 0);
      step(g);
    end
    rsp_ready = 1'b1;
    #1 check_eq("bp_release", 32'(req_ready), 32'b0010);
    step(g);
    req_valid[1] = 1'b0;
    #1 check_eq("bp_id_next", 32'(rsp_id), 1);

    // Reset mid-stall
    rsp_ready = 1'b0;
    step(g);
    rst = 1'b1;
    #1 check_eq("rst_ready", 32'(req_ready), 0);
    step(g);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(1, 1, 2, 'h33, 'h33);
    #1 check_eq("rst_valid", 32'(rsp_valid), 0);
    check_eq("rst_count", 32'(cmp_count), 0);
    check_eq("rst_first", 32'(req_ready), 32'b0010);
    step(g);
    req_valid = '0;
    step(g);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      step(g);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || i == g) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          new_data(i);
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    step(g);

    // Pointer wrap with NREQ=3
    rst3 = 1'b0;
    req_valid3 = 3'b101;
    req_sel3 = 9'b001_000_001;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("wrap_gnt", 32'(req_ready3), (k % 2 == 0) ? 32'b001 : 32'b100);
      if (k > 0) begin
        check_eq("wrap_id", 32'(rsp_id3), prev);
        check_eq("wrap_id_range", 32'(rsp_id3 == 2'd3), 0);
      end
      prev = (k % 2 == 0) ? 0 : 2;
      $display("[TB] t=%0t nreq3 grant expected req%0d", $time, prev);
      @(posedge clk);
      @(negedge clk);
    end
    #1 check_eq("wrap_id_last", 32'(rsp_id3), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares one unsigned magnitude-compare unit (SEL-coded, 8 functions) between NREQ independent requesters. Each requester issues (sel, value1, value2) over a valid/ready handshake. A round-robin arbiter grants at most one request per cycle. The result is returned one cycle later on a single registered response channel tagged with the requester index, with backpressure. The block sits between the per-lane decision logic and the shared compare datapath, so that one comparator serves all lanes.

## Interface
- N, default 8: operand width in bits.
- NREQ, default 4: number of requesters, range 2..16.
- IDW, default $clog2(NREQ): response tag width.
- clk  in  1: sole clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  NREQ: request pending, one bit per requester.
- req_ready  out  NREQ: grant; a transfer occurs on bit i when req_valid[i] && req_ready[i].
- req_sel  in  3*NREQ: requester i's SEL in bits [3i+2:3i].
- req_a  in  N*NREQ: requester i's value1 in bits [N*i+N-1:N*i].
- req_b  in  N*NREQ: requester i's value2, packed the same way.
- rsp_valid  out  1: response register holds a result.
- rsp_ready  in  1: downstream accepts the response.
- rsp_id  out  IDW: index of the requester that owns rsp_out.
- rsp_out  out  1: compare result.
- cmp_count  out  16: number of completed responses (rsp_valid && rsp_ready), wraps modulo 2^16.

## Operation
- SEL function table (unsigned compare, gt = a>b, eq = a==b):
  - 000 → 0
  - 001 → 1
  - 010 → eq
  - 011 → !eq
  - 100 → gt|eq
  - 101 → !gt
  - 110 → !(gt&eq), which is constant 1
  - 111 → gt
- Slot free: slot_free = !rsp_valid || rsp_ready. A grant is issued only when slot_free is 1.
- Arbitration: round-robin pointer rr_ptr. The search starts at rr_ptr and takes the first i (mod NREQ) with req_valid[i]=1.
  - req_ready is one-hot or zero.
  - req_ready is combinational from req_valid, rr_ptr, rsp_valid and rsp_ready.
  - req_ready does not depend on the requester's own data.
- On a grant to requester g:
  - the compare result of g's operands is loaded into rsp_out;
  - rsp_id is loaded with g, and rsp_valid is set to 1;
  - rr_ptr is loaded with (g+1) mod NREQ.
- No grant while slot_free=1: rsp_valid is cleared if rsp_ready=1. rr_ptr holds.
- Stall (rsp_valid=1, rsp_ready=0): rsp_out, rsp_id and rsp_valid hold. req_ready = 0.
- Requester contract: it holds sel/a/b stable while valid is high and not granted. The block never drops an accepted request.
- cmp_count increments on each rsp_valid && rsp_ready cycle, regardless of a simultaneous new grant.

## Timing
- Latency: a request accepted in cycle T appears on rsp_valid/rsp_out/rsp_id in cycle T+1.
- Throughput: one response per cycle when rsp_ready is held high.
- Simultaneous drain and grant: if rsp_ready=1 in a cycle where rsp_valid=1, a new grant is allowed in that same cycle. The register reloads with no bubble.
- Fairness: a requester that holds valid is granted within NREQ grants.
- Reset values: rsp_valid=0, rsp_id=0, rsp_out=0, cmp_count=0, rr_ptr=0.
- req_ready is forced to all-zero in any cycle where rst=1.
- Reset mid-stall: an unaccepted response is discarded, with no grant and no count in that cycle.
- rr_ptr wrap: NREQ-1 → 0.
- NREQ not a power of 2: rr_ptr is never loaded with an out-of-range value.

## Structure
- Shared package cmp_pkg:
  - SEL encodings as localparams: SEL_ZERO, SEL_ONE, SEL_EQ, SEL_NE, SEL_GE, SEL_LE, SEL_NAND, SEL_GT;
  - a 3-bit cmp_sel_t typedef.
- Sub-module: one instance of comparator_ds (the existing combinational compare unit), parameter N. It is fed by the granted requester's muxed sel/a/b.
- Round-robin arbiter: kept inline as a for loop over 2*NREQ indices. No separate module.

## Test plan
- Single request: after reset, NREQ=4, requester 2 presents sel=111, a=8'h90, b=8'h10. Required:
  - req_ready=4'b0100 in the same cycle;
  - next cycle rsp_valid=1, rsp_id=2, rsp_out=1;
  - cmp_count goes to 1 after the drain.
- Function sweep: for every SEL, one requester issues a=b=8'h55, then a=8'h54/b=8'h55. rsp_out must match the SEL function table, for example:
  - 110 gives 1 on both requests;
  - 101 gives 1 on both requests;
  - 010 gives 1 then 0.
- Round-robin: all four requesters hold valid continuously with rsp_ready=1. Required:
  - grant order 0,1,2,3,0,...;
  - one response per cycle;
  - cmp_count=8 after 8 cycles.
- Backpressure: rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid. Required:
  - req_ready=0 and the response registers hold;
  - on the cycle rsp_ready rises, requester 1 is granted in that same cycle, and rsp_id=1 on the next cycle.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, rst asserted for 1 cycle. Required:
  - req_ready=0 during rst;
  - afterwards rsp_valid=0, cmp_count=0, rr_ptr=0;
  - the first grant goes to the lowest valid index.
- Wrap with NREQ=3: requesters 0 and 2 are valid. Required grant sequence 0,2,0,2, with rsp_id never equal to 3.
